// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
// ----------------
// Read-side consumer for the aFIFO data interface. It issues `pop` whenever the
// FIFO has data and there is guaranteed room for the returning word. It absorbs
// the FIFO's one-cycle read latency in a 2-entry skid buffer and presents the
// words as a registered valid/ready stream. Back-to-back reads sustain one word
// per cycle, and no word is lost under backpressure.
//
// Ports:
//   clk        in   read-domain clock, rising edge
//   rst        in   asynchronous, active-high reset
//   data_out   in   FIFO read data, valid the cycle after pop is sampled
//   empty      in   FIFO empty flag
//   pop        out  FIFO read request (combinational)
//   m_data     out  stream data (registered)
//   m_valid    out  stream valid (registered)
//   m_ready    in   stream ready from the sink
//   occupancy  out  words held in the skid buffer, 0..2 (registered)
//   word_count out  completed stream handshakes, wraps (registered)

// Protocol checks for the streamer outputs; simulation-only observers.
module fifo_rd_streamer_chk #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  empty,
    input logic                  pop,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [DATA_WIDTH-1:0] m_data,
    input logic [1:0]            occupancy
);

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));

    a_occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
        occupancy <= 2'd2);

    // A stalled word stays valid and unchanged until the sink accepts it.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  empty,
    output logic                  pop,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Skid buffer storage and bookkeeping.
    data_t                skid_r [0:1];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           occupancy_r;
    logic                 inflight_r;
    logic                 m_valid_r;
    data_t                m_data_r;
    logic [CNT_WIDTH-1:0] word_count_r;

    // Combinational helpers.
    logic                 deq_s;
    logic [2:0]           level_s;
    logic [2:0]           kept_s;
    logic                 rd_ptr_next_s;
    logic [1:0]           occ_next_s;
    logic                 pop_s;
    data_t                head_s;

    // Handshake, projected fill level and pop gating.
    always_comb begin
        deq_s         = m_valid_r & m_ready;
        // Projected level = words held + word arriving - word leaving. A
        // dequeue implies occupancy >= 1, so the difference never underflows.
        level_s       = {1'b0, occupancy_r} + {2'b00, inflight_r} - {2'b00, deq_s};
        kept_s        = {1'b0, occupancy_r} - {2'b00, deq_s};
        rd_ptr_next_s = rd_ptr_r ^ deq_s;
        occ_next_s    = level_s[1:0];
        // Only pop when the returning word is guaranteed a free slot.
        if (rst) begin
            pop_s = 1'b0;
        end else begin
            pop_s = !empty && (level_s < 3'd2);
        end
    end

    // Next buffer head: the oldest word that survives this cycle.
    always_comb begin
        head_s = m_data_r;
        if (kept_s != 3'd0) begin
            head_s = skid_r[rd_ptr_next_s];
        end else if (inflight_r) begin
            // The buffer drains to nothing, so the word arriving now is the head.
            head_s = data_out;
        end else begin
            head_s = m_data_r;
        end
    end

    // Pop tracking: data returns one cycle after the pop is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= pop_s;
        end
    end

    // Capture the returning FIFO word into the skid buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_r[0] <= '0;
            skid_r[1] <= '0;
            wr_ptr_r  <= 1'b0;
        end else if (inflight_r) begin
            skid_r[wr_ptr_r] <= data_out;
            wr_ptr_r         <= ~wr_ptr_r;
        end
    end

    // Read pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            rd_ptr_r    <= rd_ptr_next_s;
            occupancy_r <= occ_next_s;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else begin
            m_valid_r <= (occ_next_s != 2'd0);
            m_data_r  <= head_s;
        end
    end

    // Delivered-word counter; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_r <= '0;
        end else if (deq_s) begin
            word_count_r <= word_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign pop        = pop_s;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign occupancy  = occupancy_r;
    assign word_count = word_count_r;

    fifo_rd_streamer_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .pop       (pop_s),
        .m_valid   (m_valid_r),
        .m_ready   (m_ready),
        .m_data    (m_data_r),
        .occupancy (occupancy_r)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a queue-backed FIFO model feeds the DUT,
// and each scenario task checks the stream against hand-computed expectations.
module tb_fifo_rd_streamer;

    logic        clk;
    logic        rst;
    logic [7:0]  data_out = 8'h00;
    logic        empty;
    logic        pop;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  occupancy;
    logic [15:0] word_count;

    int          tests;
    int          fails;
    logic [15:0] exp_count;
    logic        gate_empty;
    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q [$];

    fifo_rd_streamer #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_out   (data_out),
        .empty      (empty),
        .pop        (pop),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .occupancy  (occupancy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // FIFO read port model: one-cycle read latency.
    always @(posedge clk) begin
        if (pop) begin
            if (fifo_q.size() > 0) data_out <= fifo_q.pop_front();
            else                   data_out <= 8'h00;
        end
    end

    task automatic drive_empty();
        empty = (fifo_q.size() == 0) || gate_empty;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_empty();
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        fifo_q.push_back(8'h5A);
        drive_empty();
        #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        tests++; if (word_count !== 16'h0000) begin fails++; $display("FAIL reset_word_count: got %h expected 0000", word_count); end
        tests++; if (pop !== 1'b0) begin fails++; $display("FAIL reset_pop: got %b expected 0", pop); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pop !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL reset_pop_held: %0d cycles with pop, expected 0", bad); end
        fifo_q.delete();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_single();
        int pop_n, pop_cyc, val_n, val_cyc;
        logic [7:0] got;
        pop_n = 0; pop_cyc = -1; val_n = 0; val_cyc = -1; got = 8'h00;
        m_ready = 1'b1;
        fifo_q.push_back(8'hA5);
        drive_empty();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pop) begin pop_n++; if (pop_cyc < 0) pop_cyc = c; end
            if (m_valid) begin val_n++; if (val_cyc < 0) begin val_cyc = c; got = m_data; end end
            next_cycle();
        end
        exp_count = exp_count + 16'd1;
        tests++; if (pop_n !== 1) begin fails++; $display("FAIL single_pop_count: got %0d expected 1", pop_n); end
        tests++; if (val_n !== 1) begin fails++; $display("FAIL single_valid_cycles: got %0d expected 1", val_n); end
        tests++; if (val_cyc - pop_cyc !== 2) begin fails++; $display("FAIL single_latency: got %0d expected 2", val_cyc - pop_cyc); end
        tests++; if (got !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", got); end
        tests++; if (word_count !== exp_count) begin fails++; $display("FAIL single_word_count: got %0d expected %0d", word_count, exp_count); end
    endtask

    task automatic test_streaming();
        int hs, first, last;
        logic [7:0] exp;
        hs = 0; first = -1; last = -1;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            fifo_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        drive_empty();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                hs++;
                if (first < 0) first = c;
                last = c;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                tests++; if (m_data !== exp) begin fails++; $display("FAIL stream_data: got %h expected %h", m_data, exp); end
            end
            next_cycle();
        end
        exp_count = exp_count + 16'd16;
        tests++; if (hs !== 16) begin fails++; $display("FAIL stream_count: got %0d expected 16", hs); end
        tests++; if (last - first !== 15) begin fails++; $display("FAIL stream_bubbles: span %0d expected 15", last - first); end
        tests++; if (word_count !== exp_count) begin fails++; $display("FAIL stream_word_count: got %0d expected %0d", word_count, exp_count); end
    endtask

    task automatic test_backpressure();
        int pops, unstable, hs;
        logic rel_pop;
        logic [7:0] exp;
        pops = 0; unstable = 0; hs = 0; rel_pop = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            fifo_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        drive_empty();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pop) pops++;
            if (m_valid && m_data !== 8'h01) unstable++;
            next_cycle();
        end
        tests++; if (pops !== 2) begin fails++; $display("FAIL bp_pops: got %0d expected 2", pops); end
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occupancy: got %0d expected 2", occupancy); end
        tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
        tests++; if (m_data !== 8'h01) begin fails++; $display("FAIL bp_data: got %h expected 01", m_data); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL bp_stable: %0d unstable cycles, expected 0", unstable); end
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) rel_pop = pop;
            if (m_valid && m_ready) begin
                hs++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                tests++; if (m_data !== exp) begin fails++; $display("FAIL bp_data_order: got %h expected %h", m_data, exp); end
            end
            next_cycle();
        end
        exp_count = exp_count + 16'd8;
        tests++; if (rel_pop !== 1'b1) begin fails++; $display("FAIL bp_release_pop: got %b expected 1", rel_pop); end
        tests++; if (hs !== 8) begin fails++; $display("FAIL bp_count: got %0d expected 8", hs); end
        tests++; if (word_count !== exp_count) begin fails++; $display("FAIL bp_word_count: got %0d expected %0d", word_count, exp_count); end
    endtask

    task automatic test_reset_midstream();
        int bad, hs;
        logic [7:0] exp;
        bad = 0; hs = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h30 + 8'(i));
        drive_empty();
        for (int c = 0; c < 4; c++) next_cycle();
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL mid_pre_occupancy: got %0d expected 2", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_m_valid: got %b expected 0", m_valid); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL mid_m_data: got %h expected 00", m_data); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL mid_occupancy: got %0d expected 0", occupancy); end
        tests++; if (word_count !== 16'h0000) begin fails++; $display("FAIL mid_word_count: got %h expected 0000", word_count); end
        tests++; if (pop !== 1'b0) begin fails++; $display("FAIL mid_pop: got %b expected 0", pop); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pop !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL mid_pop_held: %0d cycles with pop, expected 0", bad); end
        next_cycle();
        rst = 1'b0;
        exp_count = 16'd0;
        // 0x30 and 0x31 were popped before reset and are lost with it.
        exp_q.delete();
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                hs++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                tests++; if (m_data !== exp) begin fails++; $display("FAIL mid_after_data: got %h expected %h", m_data, exp); end
            end
            next_cycle();
        end
        exp_count = exp_count + 16'd2;
        tests++; if (hs !== 2) begin fails++; $display("FAIL mid_after_count: got %0d expected 2", hs); end
        tests++; if (word_count !== exp_count) begin fails++; $display("FAIL mid_word_count_after: got %0d expected %0d", word_count, exp_count); end
    endtask

    task automatic test_random();
        int hs, viol, occ_bad, cyc;
        logic [7:0] w, exp;
        hs = 0; viol = 0; occ_bad = 0; cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            w = 8'($urandom_range(0, 255));
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        while (hs < 1000 && cyc < 20000) begin
            m_ready    = 1'($urandom_range(0, 1));
            gate_empty = 1'($urandom_range(0, 1));
            drive_empty();
            @(negedge clk);
            if (pop && empty) viol++;
            if (occupancy > 2'd2) occ_bad++;
            if (m_valid && m_ready) begin
                hs++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                tests++; if (m_data !== exp) begin fails++; $display("FAIL rand_data: word %0d got %h expected %h", hs, m_data, exp); end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        gate_empty = 1'b0;
        m_ready    = 1'b1;
        drive_empty();
        exp_count = exp_count + 16'd1000;
        tests++; if (hs !== 1000) begin fails++; $display("FAIL rand_count: got %0d expected 1000 (cycle budget)", hs); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL rand_pop_empty: %0d violations, expected 0", viol); end
        tests++; if (occ_bad !== 0) begin fails++; $display("FAIL rand_occupancy: %0d over-range cycles, expected 0", occ_bad); end
        tests++; if (word_count !== exp_count) begin fails++; $display("FAIL rand_word_count: got %0d expected %0d", word_count, exp_count); end
    endtask

    task automatic test_wrap();
        int n, hs, cyc;
        logic [7:0] exp;
        n = 65535 - int'(exp_count);
        hs = 0; cyc = 0;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        drive_empty();
        while (hs < n && cyc < n + 100) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                hs++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                tests++; if (m_data !== exp) begin fails++; $display("FAIL wrap_fill_data: got %h expected %h", m_data, exp); end
            end
            next_cycle();
            cyc++;
        end
        tests++; if (hs !== n) begin fails++; $display("FAIL wrap_fill_count: got %0d expected %0d (cycle budget)", hs, n); end
        tests++; if (word_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %h expected ffff", word_count); end
        hs = 0;
        fifo_q.push_back(8'hEE);
        drive_empty();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                hs++;
                tests++; if (m_data !== 8'hEE) begin fails++; $display("FAIL wrap_last_data: got %h expected ee", m_data); end
            end
            next_cycle();
        end
        tests++; if (hs !== 1) begin fails++; $display("FAIL wrap_last_count: got %0d expected 1", hs); end
        tests++; if (word_count !== 16'h0000) begin fails++; $display("FAIL wrap_post: got %h expected 0000", word_count); end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        m_ready    = 1'b0;
        gate_empty = 1'b0;
        empty      = 1'b1;
        tests      = 0;
        fails      = 0;
        exp_count  = 16'd0;
        #2;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

Read-side consumer for the aFIFO data interface: drives `pop` from `empty`, absorbs the FIFO's one-cycle read latency and presents words as a valid/ready stream. It sits on the read clock domain, between the aFIFO read port and any downstream stream sink. It contains a 2-entry skid buffer so that back-to-back reads sustain one word per cycle with no loss under backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of `data_t`, the FIFO word and the stream word.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `clk` in 1: read-domain clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_out` in DATA_WIDTH: FIFO read data, valid the cycle after `pop` is sampled.
- `empty` in 1: FIFO empty flag.
- `pop` out 1: FIFO read request, combinational.
- `m_data` out DATA_WIDTH: stream data, registered.
- `m_valid` out 1: stream valid, registered.
- `m_ready` in 1: stream ready from the sink.
- `occupancy` out 2: words held in the skid buffer (0..2), registered.
- `word_count` out CNT_WIDTH: count of completed stream handshakes, wraps.

## Operation
- Internal state:
  - `buf[0:1]`: 2-entry circular buffer with rd/wr pointers.
  - `occupancy` (0..2).
  - `inflight` flag: a pop was issued last cycle and its data is due this cycle.
- `deq = m_valid & m_ready`.
- `pop = !rst & !empty & ((occupancy + inflight - deq) < 2)`. Arithmetic is 3-bit unsigned; the term never goes negative because `deq` implies `occupancy >= 1`.
- `inflight` next = `pop`.
- Capture: when `inflight` is 1, `data_out` is written to `buf[wr_ptr]` and `wr_ptr` toggles.
- Dequeue: on `deq`, `rd_ptr` toggles.
- `occupancy` next = `occupancy + inflight - deq`.
- Simultaneous capture and dequeue is legal at any occupancy (0→0 is impossible, since `deq` needs `m_valid`). Occupancy never exceeds 2; by construction, the pop gating makes overflow unreachable.
- `m_valid` is registered and equals (next occupancy != 0). `m_data` is the registered buffer head, updated whenever the head changes. `m_data` holds its value while `m_valid & !m_ready` (AXI-style stability). Once asserted, `m_valid` does not drop without a handshake.
- `word_count` increments by 1 on every `deq` and wraps from 2^CNT_WIDTH-1 to 0.
- `pop` is never asserted while `empty` is 1, and never during reset.

## Timing
- Reset, asynchronous and immediate:
  - `m_valid` = 0, `m_data` = 0, `occupancy` = 0, `word_count` = 0.
  - `inflight` = 0, both pointers = 0.
  - `pop` = 0 while `rst` is high.
- Reset mid-operation: an in-flight FIFO word is discarded and buffered words are discarded. Because this is a whole-domain reset, the FIFO is reset alongside, so no consistency hazard exists.
- Latency, with `empty` low and buffer empty:
  - `pop` = 1 in cycle N.
  - `data_out` is captured at the edge ending cycle N+1.
  - `m_valid` = 1 in cycle N+2.
- Throughput: with `m_ready` held at 1 and `empty` held at 0, `pop` = 1 every cycle and one handshake occurs every cycle after the initial 2-cycle fill.
- Backpressure: with `m_ready` = 0, at most 2 words are popped (`occupancy` + `inflight` ≤ 2), then `pop` stays 0.
- Release: when `m_ready` returns to 1, `pop` reasserts in that same cycle through the `deq` term, with no bubble.
- `empty` rising mid-stream: `pop` drops in that same cycle. The in-flight word is still captured and delivered.

## Test plan
- Reset: assert `rst` asynchronously mid-stream with `occupancy` = 2 → all outputs 0 within the same cycle, `pop` = 0 while `rst` is high, and the first word after release is the next FIFO word.
- Single word: FIFO holds 0xA5, `m_ready` = 1 → `pop` for exactly 1 cycle, `m_valid` high 2 cycles later for 1 cycle with `m_data` = 0xA5, `word_count` = 1.
- Streaming: FIFO holds 0x01..0x10, `m_ready` = 1 → 16 consecutive handshakes in order with no bubbles after the first, `word_count` = 16.
- Backpressure: FIFO holds 0x01..0x08, `m_ready` = 0 for 10 cycles → exactly 2 pops, `occupancy` = 2, `m_data` stable at 0x01. Then `m_ready` = 1 → 0x01..0x08 delivered in order, no loss or duplication.
- Random `m_ready` (50%) against random FIFO `empty` over 1000 words → scoreboard order and value match exactly, `pop` never asserted while `empty` = 1, `occupancy` ≤ 2.
- Counter wrap: preload the stream to 65535 handshakes, then one more → `word_count` goes 0xFFFF → 0x0000.
